e_mdu: RTL and testbench

- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and executes mult/multu/div/divu over multiple cycles.
- Executes mthi/mtlo in one cycle.
- Drives the HI/LO read value that the EX/MEM register latches as the E_HILO field, and drives the busy signal that the hazard unit uses to stall mfhi/mflo/md-class instructions in D.

---
 rtl/e_mdu.sv | 88 ++++++++
 tb/tb_e_mdu.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// e_mdu: EX-stage multiply/divide unit owning HI/LO, with busy and stall_req for the hazard unit
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        req,
  input  logic        hilo_sel,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] hilo_out
);
  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);
  logic md_op, accept, sdiv, busy_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] op_q, op_n;
  logic [31:0] a, b, a_n, b_n, hi_n, lo_n, ua, ub, uq, ur, q, r;
  logic [63:0] prod;
  assign md_op = op >= 3'd1 && op <= 3'd4;
  assign accept = start && !req && !busy;
  assign sdiv = op_q == 3'd3;
  // low 64 bits of the sign-extended product equal the signed 32x32 product
  assign prod = op_q == 3'd1 ? {{32{a[31]}}, a} * {{32{b[31]}}, b} : {32'b0, a} * {32'b0, b};
  // signed divide runs on magnitudes, then fixes signs; 0x80000000/-1 wraps back to 0x80000000
  assign ua = sdiv && a[31] ? -a : a;
  assign ub = sdiv && b[31] ? -b : b;
  assign uq = ub == '0 ? '0 : ua / ub;
  assign ur = ub == '0 ? '0 : ua % ub;
  assign q = sdiv && (a[31] ^ b[31]) ? -uq : uq;
  assign r = sdiv && a[31] ? -ur : ur;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      busy <= 1'b0;
      op_q <= '0;
      a <= '0;
      b <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      cnt <= cnt_n;
      busy <= busy_n;
      op_q <= op_n;
      a <= a_n;
      b <= b_n;
      hi <= hi_n;
      lo <= lo_n;
    end
  end
  always_comb begin
    cnt_n = cnt;
    busy_n = busy;
    op_n = op_q;
    a_n = a;
    b_n = b;
    hi_n = hi;
    lo_n = lo;
    if (busy) begin
      cnt_n = cnt - 4'd1;
      busy_n = cnt != 4'd1;
      if (cnt == 4'd1 && (op_q <= 3'd2 || b != '0)) begin
        hi_n = op_q <= 3'd2 ? prod[63:32] : r;
        lo_n = op_q <= 3'd2 ? prod[31:0] : q;
      end
    end else if (accept && md_op) begin
      cnt_n = op <= 3'd2 ? MC : DC;
      busy_n = 1'b1;
      op_n = op;
      a_n = rs_val;
      b_n = rt_val;
    end else if (accept) begin
      hi_n = op == 3'd5 ? rs_val : hi;
      lo_n = op == 3'd6 ? rs_val : lo;
    end
  end
  always_comb begin
    stall_req = busy || (start && md_op && !req);
    hilo_out = hilo_sel ? hi : lo;
  end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: scoreboard bench for e_mdu; a longint reference model predicts HI/LO and busy length.
module tb_e_mdu;
  logic clk = 0, reset = 1, start = 0, req = 0, hilo_sel = 0;
  logic [2:0] op = 0;
  logic [31:0] rs_val = 0, rt_val = 0;
  logic busy, stall_req;
  logic [31:0] hi, lo, hilo_out;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int n;
  } exp_t;
  exp_t sbq[$];
  int vectors = 0, errors = 0, mcnt = 0, run_n = 0;
  bit prev_busy = 0, flushed = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  e_mdu dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .req(req), .hilo_sel(hilo_sel), .busy(busy), .stall_req(stall_req),
    .hi(hi), .lo(lo), .hilo_out(hilo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference arithmetic straight from the ISA definitions
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p, sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd1: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin p = longint'({32'b0, x}) * longint'({32'b0, y}); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd3: if (y != 0) begin m_lo = 32'(sx / sy); m_hi = 32'(sx % sy); end
      3'd4: if (y != 0) begin m_lo = x / y; m_hi = x % y; end
      default: ;
    endcase
  endtask

  // busy-time model: how many cycles remain on the in-flight op
  initial forever begin
    @(posedge clk);
    if (reset) mcnt = 0;
    else if (mcnt > 0) mcnt--;
    else if (start && !req && op >= 1 && op <= 4) mcnt = (op <= 2) ? 5 : 10;
  end

  // monitor: on every busy falling edge, pop and compare
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (busy === 1'b1) run_n++;
    else if (prev_busy) begin
      if (flushed) flushed = 0;
      else if (sbq.size() == 0) begin
        vectors++; errors++;
        $display("FAIL completion: unexpected busy drop, hi=%h lo=%h", hi, lo);
      end else begin
        e = sbq.pop_front();
        check("sb_hi", hi, e.hi);
        check("sb_lo", lo, e.lo);
        check("sb_busy_cycles", 32'(run_n), 32'(e.n));
      end
      run_n = 0;
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic r);
    bit md, acc;
    md = o >= 1 && o <= 4;
    acc = mcnt == 0 && !r;
    start = 1; op = o; rs_val = x; rt_val = y; req = r;
    #1 check("stall_req", 32'(stall_req), 32'(mcnt != 0 || (md && !r)));
    if (acc && md) begin
      model(o, x, y);
      sbq.push_back('{m_hi, m_lo, (o <= 2) ? 5 : 10});
    end
    if (acc && o == 5) m_hi = x;
    if (acc && o == 6) m_lo = x;
    tick();
    start = 0; op = 0; req = 0;
    if (acc && o == 5) begin hilo_sel = 1; #1 check("mthi_out", hilo_out, m_hi); end
    if (acc && o == 6) begin hilo_sel = 0; #1 check("mtlo_out", hilo_out, m_lo); end
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 40) begin tick(); i++; end
    if (busy) begin
      vectors++; errors++;
      $display("FAIL timeout: busy=%b after 40 cycles, expected 0", busy);
    end
    tick();
  endtask

  initial begin
    bit [2:0] o;
    logic [31:0] x, y;
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] o;
    logic [31:0] x, y;
    tick(2);
    reset = 0;
    check("rst_busy", 32'(busy), 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_stall", 32'(stall_req), 0);
    drive(3'd1, 32'hFFFFFFFE, 32'd3, 0); wait_idle();
    check("mult_hi", hi, 32'hFFFFFFFF); check("mult_lo", lo, 32'hFFFFFFFA);
    drive(3'd2, 32'hFFFFFFFE, 32'd3, 0); wait_idle();
    check("multu_hi", hi, 32'h00000002); check("multu_lo", lo, 32'hFFFFFFFA);
    drive(3'd3, 32'hFFFFFFF9, 32'd2, 0); wait_idle();
    check("div_hi", hi, 32'hFFFFFFFF); check("div_lo", lo, 32'hFFFFFFFD);
    drive(3'd4, 32'd7, 32'd2, 0); wait_idle();
    check("divu_hi", hi, 32'd1); check("divu_lo", lo, 32'd3);
    drive(3'd5, 32'h11, 32'h0, 0);
    drive(3'd6, 32'h22, 32'h0, 0);
    drive(3'd3, 32'd5, 32'd0, 0); wait_idle();
    check("div0_hi", hi, 32'h11); check("div0_lo", lo, 32'h22);
    drive(3'd1, 32'h1234, 32'h10, 0);
    tick();
    drive(3'd6, 32'hDEAD, 32'h0, 0);
    drive(3'd3, 32'd100, 32'd3, 0);
    wait_idle();
    check("ign_hi", hi, 32'h0); check("ign_lo", lo, 32'h00012340);
    drive(3'd1, 32'd7, 32'd9, 1);
    check("req_busy", 32'(busy), 0);
    check("req_hi", hi, 32'h0); check("req_lo", lo, 32'h00012340);
    drive(3'd2, 32'd6, 32'd7, 0);
    req = 1; wait_idle(); req = 0;
    check("req_run_lo", lo, 32'd42);
    drive(3'd3, 32'd100, 32'd7, 0);
    tick(2);
    reset = 1; tick();
    sbq.delete(); flushed = 1; m_hi = 0; m_lo = 0; reset = 0;
    check("abort_busy", 32'(busy), 0); check("abort_hi", hi, 0); check("abort_lo", lo, 0);
    tick(12);
    check("abort_hi_late", hi, 0); check("abort_lo_late", lo, 0);
    drive(3'd3, 32'h80000000, 32'hFFFFFFFF, 0); wait_idle();
    check("ovf_hi", hi, 32'h0); check("ovf_lo", lo, 32'h80000000);
    for (int i = 0; i < 80; i++) begin
      o = 3'($urandom_range(1, 6));
      x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      y = ($urandom_range(0, 6) == 0) ? 32'd0 : (($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom);
      drive(o, x, y, $urandom_range(0, 7) == 0);
      wait_idle();
      check("rand_hi", hi, m_hi);
      check("rand_lo", lo, m_lo);
    end
    if (sbq.size() != 0) begin
      vectors++; errors++;
      $display("FAIL scoreboard_left: %0d entries pending, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
